// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage buffers: FSM state encodings and
// the MEM/WB default widths reused by every stage instance.
package pipe_pkg;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_FULL  = 2'd1;
   localparam logic [1:0] ST_SKID  = 2'd2;

   localparam int MEMWB_DATA_W = 51;
   localparam int MEMWB_CTRL_W = 3;

endpackage

// File: rtl/pipe_slot.sv
// One W-bit storage slot: async active-low reset, sync clear (wins over load)
// and load enable.
module pipe_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ld,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] slot_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   slot_q <= '0;
      else if (clr) slot_q <= '0;
      else if (ld)  slot_q <= d;
   end

   assign q = slot_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline-stage register with optional 2-entry skid buffer
// (registered in_ready) and synchronous flush that inserts a bubble.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int DATA_W    = MEMWB_DATA_W,
   parameter int CTRL_W    = MEMWB_CTRL_W,
   parameter int SKID      = 1,
   parameter int ZERO_DATA = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   logic [1:0]        state_q, state_d;
   logic              push, pop;
   logic              main_ld, skid_ld;
   logic              main_ctrl_clr, data_clr;
   logic [CTRL_W-1:0] main_ctrl_d, skid_ctrl_q;
   logic [DATA_W-1:0] main_data_d, skid_data_q;

   assign pop  = out_valid & out_ready;
   assign push = in_valid & in_ready & ~flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_EMPTY;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      main_ld = 1'b0;
      skid_ld = 1'b0;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (push) begin
               state_d = ST_FULL;
               main_ld = 1'b1;
            end
            ST_FULL: begin
               if (push && pop) begin
                  main_ld = 1'b1;
               end else if (push && (SKID != 0)) begin
                  state_d = ST_SKID;
                  skid_ld = 1'b1;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_SKID: if (pop) begin
               state_d = ST_FULL;
               main_ld = 1'b1;
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_comb begin
      out_valid = (state_q != ST_EMPTY);
      occupancy = state_q;
   end

   // The skid beat always refills the main slot before any new beat can enter.
   assign main_ctrl_d   = (state_q == ST_SKID) ? skid_ctrl_q : in_ctrl;
   assign main_data_d   = (state_q == ST_SKID) ? skid_data_q : in_data;
   assign main_ctrl_clr = (state_d == ST_EMPTY);
   assign data_clr      = (ZERO_DATA != 0) & flush;

   pipe_slot #(.W(CTRL_W)) u_main_ctrl (
      .clk(clk), .rst_n(rst), .ld(main_ld), .clr(main_ctrl_clr),
      .d(main_ctrl_d), .q(out_ctrl)
   );

   pipe_slot #(.W(DATA_W)) u_main_data (
      .clk(clk), .rst_n(rst), .ld(main_ld), .clr(data_clr),
      .d(main_data_d), .q(out_data)
   );

   generate
      if (SKID != 0) begin : g_skid
         logic in_ready_q;

         pipe_slot #(.W(CTRL_W)) u_skid_ctrl (
            .clk(clk), .rst_n(rst), .ld(skid_ld), .clr(flush),
            .d(in_ctrl), .q(skid_ctrl_q)
         );

         pipe_slot #(.W(DATA_W)) u_skid_data (
            .clk(clk), .rst_n(rst), .ld(skid_ld), .clr(data_clr),
            .d(in_data), .q(skid_data_q)
         );

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) in_ready_q <= 1'b0;
            else      in_ready_q <= (state_d != ST_SKID);
         end

         assign in_ready = in_ready_q;
      end else begin : g_noskid
         assign skid_ctrl_q = '0;
         assign skid_data_q = '0;
         assign in_ready    = rst & (~out_valid | out_ready);
      end
   endgenerate

   a_occ_legal : assert property (@(posedge clk) disable iff (!rst) state_q != 2'd3);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench: a SKID=1 MEM/WB-width instance and a SKID=0 narrow instance.
module tb_pipe_stage_buf;
   import pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   int          n_cmp  = 0;
   int          n_fail = 0;

   logic        flush, in_valid, in_ready, out_valid, out_ready;
   logic [2:0]  in_ctrl, out_ctrl;
   logic [50:0] in_data, out_data;
   logic [1:0]  occupancy;

   logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0;
   logic [2:0]  in_ctrl0, out_ctrl0;
   logic [7:0]  in_data0, out_data0;
   logic [1:0]  occupancy0;

   always #5 clk = ~clk;

   pipe_stage_buf u_dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy)
   );

   pipe_stage_buf #(.DATA_W(8), .CTRL_W(3), .SKID(0), .ZERO_DATA(0)) u_dut0 (
      .clk(clk), .rst(rst), .flush(flush0), .in_valid(in_valid0), .in_ready(in_ready0),
      .in_ctrl(in_ctrl0), .in_data(in_data0), .out_valid(out_valid0), .out_ready(out_ready0),
      .out_ctrl(out_ctrl0), .out_data(out_data0), .occupancy(occupancy0)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      flush = 0; in_valid = 0; out_ready = 0; in_ctrl = 0; in_data = 0;
      flush0 = 0; in_valid0 = 0; out_ready0 = 0; in_ctrl0 = 0; in_data0 = 0;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         flush = 1'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
         in_ctrl = 3'($urandom); in_data = {19'($urandom), 32'($urandom)};
         flush0 = 1'($urandom); in_valid0 = 1'($urandom); out_ready0 = 1'($urandom);
         in_ctrl0 = 3'($urandom); in_data0 = 8'($urandom);
         tick();
      end
      n_cmp++; if ({out_valid, out_ctrl, occupancy, in_ready} !== 7'b0) begin n_fail++; $display("FAIL reset_ctl got v=%b c=%b o=%0d r=%b want all 0", out_valid, out_ctrl, occupancy, in_ready); end
      n_cmp++; if (out_data !== 51'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
      n_cmp++; if ({out_valid0, out_ctrl0, occupancy0, in_ready0, out_data0} !== 15'b0) begin n_fail++; $display("FAIL reset_s0 got v=%b c=%b o=%0d r=%b d=%h want all 0", out_valid0, out_ctrl0, occupancy0, in_ready0, out_data0); end
      idle_inputs();
      rst = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rel_ready_pre got %b want 0", in_ready); end
      n_cmp++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL rel_ready_s0 got %b want 1", in_ready0); end
      tick();
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready_post got %b want 1", in_ready); end
   endtask

   task automatic test_streaming;
      in_valid = 1; out_ready = 1; in_ctrl = 3'b101;
      for (int i = 1; i <= 8; i++) begin
         in_data = 51'(i);
         tick();
         n_cmp++; if ({out_valid, out_ctrl, occupancy, in_ready} !== {1'b1, 3'b101, 2'd1, 1'b1} || out_data !== 51'(i))
            begin n_fail++; $display("FAIL stream_%0d got v=%b c=%b o=%0d r=%b d=%h want 1 101 1 1 %h", i, out_valid, out_ctrl, occupancy, in_ready, out_data, i); end
      end
      in_valid = 0;
      tick();
      n_cmp++; if ({out_valid, out_ctrl, occupancy} !== 6'b0) begin n_fail++; $display("FAIL stream_drain got v=%b c=%b o=%0d want 0", out_valid, out_ctrl, occupancy); end
   endtask

   task automatic test_backpressure;
      out_ready = 0; in_valid = 1; in_ctrl = 3'b101; in_data = 51'hA;
      tick();
      n_cmp++; if (occupancy !== 2'd1 || out_data !== 51'hA || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first got o=%0d d=%h r=%b want 1 a 1", occupancy, out_data, in_ready); end
      in_data = 51'hB;
      tick();
      n_cmp++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 51'hA) begin n_fail++; $display("FAIL bp_skid got o=%0d r=%b d=%h want 2 0 a", occupancy, in_ready, out_data); end
      in_valid = 0; in_data = 51'hD;
      tick();
      n_cmp++; if (occupancy !== 2'd2 || out_data !== 51'hA || out_ctrl !== 3'b101) begin n_fail++; $display("FAIL bp_hold got o=%0d d=%h c=%b want 2 a 101", occupancy, out_data, out_ctrl); end
      out_ready = 1;
      tick();
      n_cmp++; if (occupancy !== 2'd1 || out_data !== 51'hB || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_pop1 got o=%0d d=%h r=%b want 1 b 1", occupancy, out_data, in_ready); end
      tick();
      n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 3'b0) begin n_fail++; $display("FAIL bp_pop2 got o=%0d v=%b c=%b want 0 0 0", occupancy, out_valid, out_ctrl); end
   endtask

   task automatic test_flush;
      out_ready = 0; in_valid = 1; in_ctrl = 3'b111; in_data = 51'h1E;
      tick();
      in_data = 51'h1F;
      tick();
      n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL fl_setup got o=%0d want 2", occupancy); end
      in_data = 51'hC; flush = 1;
      tick();
      n_cmp++; if ({occupancy, out_valid, out_ctrl} !== 6'b0) begin n_fail++; $display("FAIL fl_clear got o=%0d v=%b c=%b want 0", occupancy, out_valid, out_ctrl); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_ready got %b want 1", in_ready); end
      flush = 0; in_valid = 0; out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_noemit_%0d got v=%b d=%h want v=0", i, out_valid, out_data); end
      end
   endtask

   task automatic test_noskid;
      out_ready0 = 0; in_valid0 = 1; in_ctrl0 = 3'b010; in_data0 = 8'h11;
      tick();
      n_cmp++; if (out_valid0 !== 1'b1 || out_data0 !== 8'h11 || out_ctrl0 !== 3'b010) begin n_fail++; $display("FAIL s0_load got v=%b d=%h c=%b want 1 11 010", out_valid0, out_data0, out_ctrl0); end
      n_cmp++; if (in_ready0 !== 1'b0 || occupancy0 !== 2'd1) begin n_fail++; $display("FAIL s0_full_ready got r=%b o=%0d want 0 1", in_ready0, occupancy0); end
      in_data0 = 8'h22; in_ctrl0 = 3'b001;
      tick();
      n_cmp++; if (out_data0 !== 8'h11) begin n_fail++; $display("FAIL s0_hold got %h want 11", out_data0); end
      out_ready0 = 1;
      #1;
      n_cmp++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL s0_comb_ready got %b want 1", in_ready0); end
      tick();
      n_cmp++; if (out_valid0 !== 1'b1 || out_data0 !== 8'h22 || out_ctrl0 !== 3'b001 || occupancy0 !== 2'd1) begin n_fail++; $display("FAIL s0_replace got v=%b d=%h c=%b o=%0d want 1 22 001 1", out_valid0, out_data0, out_ctrl0, occupancy0); end
      in_valid0 = 0;
      tick();
      n_cmp++; if (out_valid0 !== 1'b0 || out_ctrl0 !== 3'b0) begin n_fail++; $display("FAIL s0_drain got v=%b c=%b want 0 0", out_valid0, out_ctrl0); end
   endtask

   task automatic test_async_reset;
      out_ready = 0; in_valid = 1; in_ctrl = 3'b110; in_data = 51'h5;
      out_ready0 = 0; in_valid0 = 1; in_ctrl0 = 3'b110; in_data0 = 8'h5;
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_valid0 !== 1'b1) begin n_fail++; $display("FAIL ar_setup got v=%b v0=%b want 1 1", out_valid, out_valid0); end
      in_data = 51'h6; in_data0 = 8'h6;
      #2 rst = 1'b0;
      #1;
      n_cmp++; if ({out_valid, out_ctrl, occupancy} !== 6'b0 || out_data !== 51'd0) begin n_fail++; $display("FAIL ar_drop got v=%b c=%b o=%0d d=%h want 0", out_valid, out_ctrl, occupancy, out_data); end
      n_cmp++; if ({out_valid0, out_ctrl0, occupancy0, in_ready0} !== 7'b0) begin n_fail++; $display("FAIL ar_drop_s0 got v=%b c=%b o=%0d r=%b want 0", out_valid0, out_ctrl0, occupancy0, in_ready0); end
      tick();
      idle_inputs();
      out_ready = 1; out_ready0 = 1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (out_valid !== 1'b0 || out_valid0 !== 1'b0) begin n_fail++; $display("FAIL ar_stale_%0d got v=%b v0=%b want 0 0", i, out_valid, out_valid0); end
      end
   endtask

   initial begin
      idle_inputs();
      rst = 1'b0;
      tick();
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_noskid();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
